// File: rtl/req_arbiter_if.sv
// Handshake and command bus between the two request clients, the arbiter
// and the downstream command FSM.
interface req_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          wr_req;
  logic          rd_req;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          busy;

  // Client / FSM side: drives requests, observes ready and issue pulses
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, wr_req, rd_req, req_addr, req_data, busy
  );

  // Arbiter side
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, wr_req, rd_req, req_addr, req_data, busy
  );
endinterface

// File: rtl/req_arbiter.sv
// Round-robin write/read request arbiter with one-entry holding slot per
// client and a guard window between issue pulses so the command FSM is
// never handed a new request while it is mid-sequence.
module req_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int GAP = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  req_arbiter_if.slave bus
);

  localparam int CW = $clog2(GAP) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_holdCnt;
  logic          r_lastGrantRd;
  logic          r_grantWr;

  logic          r_wrPending;
  logic          r_wrReady;
  logic [AW-1:0] r_wrAddr;
  logic [DW-1:0] r_wrData;
  logic          r_rdPending;
  logic          r_rdReady;
  logic [AW-1:0] r_rdAddr;

  logic          r_wrReq;
  logic          r_rdReq;
  logic [AW-1:0] r_reqAddr;
  logic [DW-1:0] r_reqData;
  logic          r_busy;

  logic          w_wrTake;
  logic          w_rdTake;
  logic          w_wrPendNext;
  logic          w_rdPendNext;
  logic          w_pickWr;

  // Slot capture/release and the round-robin choice between pending slots
  always_comb begin
    w_wrTake     = bus.wr_valid & r_wrReady;
    w_rdTake     = bus.rd_valid & r_rdReady;
    w_wrPendNext = w_wrTake | (r_wrPending & ~((r_state == ISSUE) & r_grantWr));
    w_rdPendNext = w_rdTake | (r_rdPending & ~((r_state == ISSUE) & ~r_grantWr));
    w_pickWr     = r_wrPending & (~r_rdPending | r_lastGrantRd);
  end

  // Holding slots: ready is the registered inverse of the next pending flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPending <= 1'b0;
      r_wrReady   <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_rdPending <= 1'b0;
      r_rdReady   <= 1'b0;
      r_rdAddr    <= '0;
    end else begin
      r_wrPending <= w_wrPendNext;
      r_wrReady   <= ~w_wrPendNext;
      r_rdPending <= w_rdPendNext;
      r_rdReady   <= ~w_rdPendNext;
      if (w_wrTake) begin
        r_wrAddr <= bus.wr_addr;
        r_wrData <= bus.wr_data;
      end
      if (w_rdTake) begin
        r_rdAddr <= bus.rd_addr;
      end
    end
  end

  // Arbitration FSM with registered issue pulses, command bus and busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_holdCnt     <= '0;
      r_lastGrantRd <= 1'b1;
      r_grantWr     <= 1'b0;
      r_wrReq       <= 1'b0;
      r_rdReq       <= 1'b0;
      r_reqAddr     <= '0;
      r_reqData     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_wrReq <= 1'b0;
      r_rdReq <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_wrPending | r_rdPending) begin
            r_state       <= ISSUE;
            r_busy        <= 1'b1;
            r_grantWr     <= w_pickWr;
            r_lastGrantRd <= ~w_pickWr;
            r_wrReq       <= w_pickWr;
            r_rdReq       <= ~w_pickWr;
            r_reqAddr     <= w_pickWr ? r_wrAddr : r_rdAddr;
            r_reqData     <= w_pickWr ? r_wrData : '0;
          end
        end
        ISSUE: begin
          r_state   <= HOLD;
          r_holdCnt <= CW'(GAP - 2);
          r_busy    <= 1'b1;
        end
        HOLD: begin
          if (r_holdCnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_holdCnt <= r_holdCnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready = r_wrReady;
  assign bus.rd_ready = r_rdReady;
  assign bus.wr_req   = r_wrReq;
  assign bus.rd_req   = r_rdReq;
  assign bus.req_addr = r_reqAddr;
  assign bus.req_data = r_reqData;
  assign bus.busy     = r_busy;

endmodule
